cnt_seq_checker: RTL and testbench
==================================

Name: cnt_seq_checker

Overview:
- Receiving end of the 4-bit free-running counter stream.
- Samples the counter value `q` on each enabled clock and predicts the next value (increment or decrement, selected by `dir`).
- Acquires lock after a run of consecutive correct samples, flags mismatches, counts errors, and drops lock on repeated misses.
- Sits beside the counter in the bench and system so that count integrity and wrap-around are checked in hardware.

Parameters:
- WIDTH, 4, bit width of the counter value under check.
- LOCK_RUN, 3, consecutive matching samples needed to go from ACQUIRE to LOCKED.
- UNLOCK_ERRS, 2, consecutive mismatches while LOCKED that force a return to ACQUIRE.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; `q` is evaluated only on cycles with en=1.
- q  input  WIDTH  observed counter value.
- dir  input  1  expected direction: 0 = up (+1), 1 = down (-1).
- expected  output  WIDTH  predicted next sample; combinational from the internal ref and dir.
- locked  output  1  high while the FSM is in LOCKED.
- err  output  1  one-cycle pulse on a mismatch while LOCKED.
- wrap  output  1  one-cycle pulse on a matching sample equal to the wrap value while LOCKED.
- err_count  output  ERR_W  total mismatches seen while LOCKED; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything:
  - state=IDLE, ref=0, run=0, miss=0.
  - err=0, wrap=0, err_count=0, locked=0.
- A reset during any state takes effect at that edge; there is no partial retention.
- Prediction: exp = dir ? ref-1 : ref+1, modulo 2^WIDTH. `expected` = exp at all times.
  - So after reset, expected = 1 when dir=0 and = F when dir=1.
- match = (q == exp), evaluated only when en=1.
- en=0: state, ref, run, miss and err_count hold; err and wrap are 0.
- All registered outputs update at the edge of the sampled cycle and are visible the following cycle.
  - Latency from sample to err/wrap/locked is 1 clock.
- IDLE:
  - On en=1: ref<=q, run<=0, go to ACQUIRE.
  - No compare is performed.
- ACQUIRE:
  - On en=1, always ref<=q, re-synchronising to the stream.
  - On match: run<=run+1. If run+1 == LOCK_RUN, go to LOCKED with miss<=0.
  - On mismatch: run<=0.
  - err is never asserted and err_count never changes in this state.
- LOCKED (flywheel): on en=1, ref<=exp regardless of match, so a single glitch does not shift alignment.
  - On match: miss<=0.
  - On match with exp==0 (dir=0) or exp==all-ones (dir=1): wrap<=1.
  - On mismatch:
    - err<=1, err_count<=err_count+1 unless already all-ones, miss<=miss+1.
    - If miss+1 == UNLOCK_ERRS: go to ACQUIRE with ref<=q, run<=0, locked drops next cycle.
- dir may change on any cycle. The new direction applies to that cycle's prediction, with no extra state; a reversal while LOCKED is checked like any other sample.
- Width rules:
  - `run` counter width is clog2(LOCK_RUN+1); `miss` width is clog2(UNLOCK_ERRS+1).
  - Both counters are unsigned.
  - WIDTH arithmetic wraps naturally.
- LOCK_RUN=1 is legal: one match from ACQUIRE locks.
- UNLOCK_ERRS=1 is legal: any miss unlocks, and err still pulses for that sample.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2) and a clog2 helper function.
- One natural sub-module: `sat_counter` (parameter W; inputs clk, rst, inc; output cnt; holds at all-ones).
  - Used for err_count.
- The FSM, prediction and ref register stay in cnt_seq_checker.

Test Plan:
- Clean lock:
  - Stimulus: rst 1 cycle, dir=0, en=1, q=0,1,2,3,4…
  - Required: IDLE takes q=0. The matches at q=1,2,3 give run=3, so locked=1 the cycle after the q=3 sample. err never pulses; err_count=0.
- Wrap:
  - Stimulus: continue the locked up-count through q=E,F,0.
  - Required: wrap pulses exactly once, the cycle after q=0, and again every 16 samples.
  - Stimulus: with dir=1 and q counting down.
  - Required: wrap pulses after q=F.
- Single glitch:
  - Stimulus: locked at ref=5, then q=6,9,8.
  - Required: err pulses once, after q=9; err_count=1. q=8 matches via the flywheel (ref=7), and locked stays 1.
- Loss of lock:
  - Stimulus: locked at ref=5, then q=A,A,B,C,D.
  - Required: err pulses twice and err_count=2. After the second A, locked drops and ref=A. B, C and D re-lock (locked=1 after D). No err in ACQUIRE.
- Enable, saturation and reset:
  - Stimulus: en=0 for 5 cycles with garbage q.
  - Required: all state holds, no pulses.
  - Stimulus: force 300 mismatches by re-locking repeatedly.
  - Required: err_count stops at 255.
  - Stimulus: rst mid-LOCKED.
  - Required: next cycle locked=0, err_count=0, expected=1 with dir=0.

Source files
------------

// File: rtl/cnt_seq_checker_pkg.sv
// cnt_seq_checker_pkg: shared state encoding and width helper for the counter stream checker
package cnt_seq_checker_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/cnt_seq_checker_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: predicts the next counter sample, locks after a clean run, flags and counts misses while locked
module cnt_seq_checker
  import cnt_seq_checker_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LOCK_RUN    = 3,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);
  localparam int RUN_W  = clog2(LOCK_RUN + 1);
  localparam int MISS_W = clog2(UNLOCK_ERRS + 1);
  state_t              r_state;
  logic [WIDTH-1:0]    r_ref;
  logic [RUN_W-1:0]    r_run;
  logic [MISS_W-1:0]   r_miss;
  logic                r_err;
  logic                r_wrap;
  logic [WIDTH-1:0]    w_exp;
  logic                w_match;
  logic [RUN_W-1:0]    w_run_nx;
  logic [MISS_W-1:0]   w_miss_nx;
  logic [WIDTH-1:0]    w_wrap_val;
  logic                w_err_inc;
  assign w_exp      = dir ? r_ref - 1'b1 : r_ref + 1'b1;
  assign w_match    = q == w_exp;
  assign w_run_nx   = r_run + 1'b1;
  assign w_miss_nx  = r_miss + 1'b1;
  assign w_wrap_val = dir ? '1 : '0;
  assign w_err_inc  = en && r_state == LOCKED && !w_match;
  assign expected   = w_exp;
  assign locked     = r_state == LOCKED;
  assign err        = r_err;
  assign wrap       = r_wrap;
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_err_inc),
    .cnt(err_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ref   <= '0;
      r_run   <= '0;
      r_miss  <= '0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
      if (en) begin
        case (r_state)
          IDLE: begin
            r_ref   <= q;
            r_run   <= '0;
            r_state <= ACQUIRE;
          end
          ACQUIRE: begin
            r_ref <= q;
            r_run <= w_match ? w_run_nx : '0;
            if (w_match && w_run_nx == RUN_W'(LOCK_RUN)) begin
              r_state <= LOCKED;
              r_miss  <= '0;
            end
          end
          LOCKED: begin
            // flywheel: keep our own phase so one glitch does not shift alignment
            r_ref <= w_exp;
            if (w_match) begin
              r_miss <= '0;
              r_wrap <= w_exp == w_wrap_val;
            end else begin
              r_err  <= 1'b1;
              r_miss <= w_miss_nx;
              if (w_miss_nx == MISS_W'(UNLOCK_ERRS)) begin
                r_state <= ACQUIRE;
                r_ref   <= q;
                r_run   <= '0;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb_cnt_seq_checker: randomized + directed stimulus, behavioural model feeds a scoreboard checked by a monitor
module tb_cnt_seq_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] q = '0;
  logic       dir = 1'b0;
  logic [3:0] expected;
  logic       locked, err, wrap;
  logic [7:0] err_count;
  typedef struct packed {
    logic [3:0] e;
    logic       l;
    logic       er;
    logic       w;
    logic [7:0] c;
  } item_t;
  item_t sb[$];
  int tests = 0;
  int fails = 0;
  int m_mode = 0;
  int m_ref = 0, m_run = 0, m_miss = 0, m_ec = 0;
  bit m_err = 0, m_wrap = 0;
  always #5 clk = ~clk;
  cnt_seq_checker dut (
    .clk(clk), .rst(rst), .en(en), .q(q), .dir(dir),
    .expected(expected), .locked(locked), .err(err), .wrap(wrap), .err_count(err_count)
  );
  function automatic int pred(input int rf, input logic d);
    return (rf + (d ? 15 : 1)) % 16;
  endfunction
  // model modes: 0 waiting for first sample, 1 hunting for a clean run, 2 locked flywheel
  task automatic step(input logic r, input logic e, input int qq, input logic d);
    int p;
    @(negedge clk);
    rst = r; en = e; q = 4'(qq); dir = d;
    p = pred(m_ref, d);
    m_err = 0; m_wrap = 0;
    if (r) begin
      m_mode = 0; m_ref = 0; m_run = 0; m_miss = 0; m_ec = 0;
    end else if (e) begin
      if (m_mode == 0) begin
        m_ref = qq; m_run = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        m_ref = qq;
        m_run = (qq == p) ? m_run + 1 : 0;
        if (m_run == 3) begin m_mode = 2; m_miss = 0; end
      end else if (qq == p) begin
        m_miss = 0; m_ref = p;
        m_wrap = (p == (d ? 15 : 0));
      end else begin
        m_err = 1; m_miss++;
        if (m_ec < 255) m_ec++;
        if (m_miss == 2) begin m_mode = 1; m_ref = qq; m_run = 0; end
        else m_ref = p;
      end
    end
    sb.push_back('{e: 4'(pred(m_ref, d)), l: m_mode == 2, er: m_err, w: m_wrap, c: 8'(m_ec)});
  endtask
  task automatic good(input logic d);
    step(0, 1, pred(m_ref, d), d);
  endtask
  task automatic bad(input logic d);
    step(0, 1, pred(m_ref, d) + 5, d);
  endtask
  initial begin
    item_t it, got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        got = '{e: expected, l: locked, er: err, w: wrap, c: err_count};
        tests++;
        if (got !== it) begin
          fails++;
          $display("FAIL out t=%0t got exp=%h lk=%b err=%b wrap=%b cnt=%0d want exp=%h lk=%b err=%b wrap=%b cnt=%0d",
                   $time, got.e, got.l, got.er, got.w, got.c, it.e, it.l, it.er, it.w, it.c);
        end
      end
    end
  end
  initial begin
    logic d;
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, i % 16, 0);
    for (int i = 0; i < 24; i++) good(1);
    repeat (2) good(0);
    bad(0); good(0); good(0);
    bad(0); bad(0);
    repeat (4) good(0);
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(15), $urandom_range(1));
    good(0); good(1);
    for (int i = 0; i < 150; i++) begin
      repeat (4) good(i[0]);
      bad(i[0]); bad(i[0]);
    end
    repeat (4) good(0);
    d = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(19) == 0) d = ~d;
      if ($urandom_range(99) < 80) step(0, $urandom_range(6) != 0, pred(m_ref, d), d);
      else step(0, $urandom_range(6) != 0, $urandom_range(15), d);
      if (i == 1000) step(1, 1, $urandom_range(15), d);
    end
    repeat (5) good(0);
    step(1, 1, 7, 0);
    step(0, 0, 3, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
